// File: rtl/norm_engine_if.sv
// norm_engine_if: start/result handshake and host BRAM port of norm_engine.
// The engine connects through the slave modport; the host side uses master.
interface norm_engine_if #(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64
);
    logic                     r_enable;
    logic [63:0]              init_i;
    logic [ADDR_W:0]          n;
    logic [ACC_W-1:0]         init_acc;
    logic [1:0]               mode;
    logic                     w_enable;
    logic [ACC_W-1:0]         result;
    logic                     busy;
    logic                     overflow;
    logic                     controlArr;
    logic                     controlArrWEnable_a;
    logic [ADDR_W-1:0]        controlArrAddr_a;
    logic signed [DATA_W-1:0] controlArrWData_a;
    logic signed [DATA_W-1:0] controlArrRData_a;

    modport master (
        output r_enable, init_i, n, init_acc, mode,
        output controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
        input  w_enable, result, busy, overflow, controlArrRData_a
    );

    modport slave (
        input  r_enable, init_i, n, init_acc, mode,
        input  controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
        output w_enable, result, busy, overflow, controlArrRData_a
    );
endinterface

// File: rtl/norm_engine.sv
// norm_engine: reduces a run of signed elements held in an internal
// single-port BRAM to sum of squares (mode 0/3), sum of magnitudes (mode 1)
// or maximum magnitude (mode 2). The host loads/reads the BRAM while idle.
// Build macro NORM_ENGINE_SAT_EN: modes 0/1 saturate at 2**ACC_W-1 instead
// of wrapping; overflow is flagged in both builds.
module norm_engine #(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    norm_engine_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     n_q, k_q, k_next;
    logic [1:0]          mode_q;
    logic [ACC_W-1:0]    acc_q, acc_d, result_q, val_ext;
    logic [ACC_W:0]      sum;
    logic                carry, ovf_q, ovf_out_q;
    logic                rd_valid_q, op_valid_q;
    logic [PROD_W-1:0]   op_val_q, op_val_d;
    logic [DATA_W-1:0]   rdata_q, abs_x;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [ADDR_W-1:0]   mem_addr;
    logic                start, host_own;
    logic                unused_init_hi;

    assign start          = (state_q == IDLE) && bus.r_enable && !bus.controlArr;
    assign host_own       = (state_q == IDLE) && bus.controlArr;
    assign k_next         = k_q + 1'b1;
    assign mem_addr       = host_own ? bus.controlArrAddr_a : base_q + k_q[ADDR_W-1:0];
    assign unused_init_hi = ^bus.init_i[63:ADDR_W];

    assign bus.busy              = (state_q != IDLE);
    assign bus.w_enable          = (state_q == DONE);
    assign bus.result            = result_q;
    assign bus.overflow          = ovf_out_q;
    assign bus.controlArrRData_a = rdata_q;

    // State register; a reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: issue n addresses, wait for the pipeline to empty, then publish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (bus.n == '0) ? DRAIN : RUN;
            RUN:     if (k_next == n_q) state_d = DRAIN;
            DRAIN:   if (!rd_valid_q && !op_valid_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // BRAM array: only the host writes, and only while it owns the port.
    always_ff @(posedge clk) begin
        if (host_own && bus.controlArrWEnable_a) mem[mem_addr] <= bus.controlArrWData_a;
    end

    // Synchronous read register shared by the host readback and the engine.
    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= mem[mem_addr];
    end

    // Magnitude (most negative value maps to its exact unsigned magnitude) and square.
    always_comb begin
        abs_x    = rdata_q[DATA_W-1] ? (~rdata_q + 1'b1) : rdata_q;
        op_val_d = PROD_W'(abs_x) * PROD_W'(abs_x);
        if (mode_q == 2'd1 || mode_q == 2'd2) op_val_d = PROD_W'(abs_x);
    end

    // Accumulate step: max for mode 2, otherwise add with carry detection.
    always_comb begin
        val_ext = ACC_W'(op_val_q);
        sum     = {1'b0, acc_q} + {1'b0, val_ext};
        carry   = 1'b0;
        acc_d   = acc_q;
        if (mode_q == 2'd2) begin
            if (val_ext > acc_q) acc_d = val_ext;
        end else begin
            carry = sum[ACC_W];
`ifdef NORM_ENGINE_SAT_EN
            acc_d = carry ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
        end
    end

    // Run bookkeeping, pipeline valid flags, accumulator and published outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            n_q        <= '0;
            k_q        <= '0;
            mode_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            ovf_out_q  <= 1'b0;
            result_q   <= '0;
            rd_valid_q <= 1'b0;
            op_valid_q <= 1'b0;
            op_val_q   <= '0;
        end else begin
            rd_valid_q <= (state_q == RUN);
            op_valid_q <= rd_valid_q;
            op_val_q   <= op_val_d;
            if (start) begin
                base_q    <= bus.init_i[ADDR_W-1:0];
                n_q       <= bus.n;
                mode_q    <= bus.mode;
                acc_q     <= bus.init_acc;
                k_q       <= '0;
                ovf_q     <= 1'b0;
                ovf_out_q <= 1'b0;
            end else begin
                if (state_q == RUN) k_q <= k_next;
                if (op_valid_q) begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_q | carry;
                end
            end
            if (state_q == DRAIN && state_d == DONE) begin
                result_q  <= acc_q;
                ovf_out_q <= ovf_q;
            end
        end
    end
endmodule

// File: tb/tb_norm_engine.sv
// tb_norm_engine: randomized and directed runs on two engines (64-bit and
// 54-bit accumulators) sharing one stimulus stream; a scoreboard queue per
// engine is filled by the stimulus and drained by a monitor on w_enable.
module tb_norm_engine;
    localparam int DATA_W = 27;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
`ifdef NORM_ENGINE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        int          startCyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   memModel [DEPTH];
    exp_t exp64Q [$];
    exp_t exp54Q [$];

    norm_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(64)) bus ();
    norm_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(54)) bus54 ();

    assign bus54.r_enable            = bus.r_enable;
    assign bus54.init_i              = bus.init_i;
    assign bus54.n                   = bus.n;
    assign bus54.init_acc            = bus.init_acc[53:0];
    assign bus54.mode                = bus.mode;
    assign bus54.controlArr          = bus.controlArr;
    assign bus54.controlArrWEnable_a = bus.controlArrWEnable_a;
    assign bus54.controlArrAddr_a    = bus.controlArrAddr_a;
    assign bus54.controlArrWData_a   = bus.controlArrWData_a;

    norm_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    norm_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(54)) dut54 (
        .clk(clk), .rst_n(rst_n), .bus(bus54)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: walk the run index by index with wide plain arithmetic.
    function automatic logic [64:0] refNorm(input int base, input int cnt, input int md,
                                            input logic [63:0] seed, input int accW);
        logic [64:0] lim, acc, v;
        logic        ovf;
        longint      ax;
        int          x;
        lim = 65'd1 << accW;
        acc = {1'b0, seed} % lim;
        ovf = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            x  = memModel[(base + k) % DEPTH];
            ax = (x < 0) ? -longint'(x) : longint'(x);
            if (md == 1 || md == 2) v = 65'(ax);
            else                    v = 65'(ax * ax);
            if (md == 2) begin
                if (v > acc) acc = v;
            end else begin
                acc = acc + v;
                if (acc >= lim) begin
                    ovf = 1'b1;
                    acc = SAT ? lim - 65'd1 : acc % lim;
                end
            end
        end
        return {ovf, acc[63:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic loadWord(input int addr, input int val);
        bus.controlArr          = 1'b1;
        bus.controlArrWEnable_a = 1'b1;
        bus.controlArrAddr_a    = 10'(addr);
        bus.controlArrWData_a   = 27'(val);
        memModel[addr]          = val;
        @(negedge clk);
        bus.controlArrWEnable_a = 1'b0;
    endtask

    task automatic checkReadback(input int addr);
        logic [26:0] got, want;
        bus.controlArr          = 1'b1;
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrAddr_a    = 10'(addr);
        @(negedge clk);
        got  = bus.controlArrRData_a;
        want = 27'(memModel[addr]);
        checkOutput("readback", 64'(got), 64'(want));
    endtask

    task automatic checkResetState();
        checkOutput("reset w_enable", 64'(bus.w_enable), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset overflow", 64'(bus.overflow), 64'd0);
        checkOutput("reset result", bus.result, 64'd0);
        checkOutput("reset rdata", 64'(unsigned'(bus.controlArrRData_a)), 64'd0);
        checkOutput("reset result54", 64'(bus54.result), 64'd0);
    endtask

    // Start one run once the engine is idle; queue its expected outcome.
    task automatic applyStimulus(input logic [63:0] initI, input int cnt, input logic [1:0] md,
                                 input logic [63:0] seed, input bit expectDone);
        logic [64:0] r64, r54;
        exp_t        e;
        int          guard = 0;
        while (bus.busy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) reportTimeout("start wait");
        bus.controlArr          = 1'b0;
        bus.controlArrWEnable_a = 1'b0;
        bus.init_i              = initI;
        bus.n                   = 11'(cnt);
        bus.mode                = md;
        bus.init_acc            = seed;
        bus.r_enable            = 1'b1;
        if (expectDone) begin
            r64        = refNorm(int'(initI[9:0]), cnt, int'(md), seed, 64);
            r54        = refNorm(int'(initI[9:0]), cnt, int'(md), seed, 54);
            e.startCyc = cyc;
            e.lat      = (cnt == 0) ? 2 : cnt + 4;
            e.res      = r64[63:0];
            e.ovf      = r64[64];
            exp64Q.push_back(e);
            e.res      = r54[63:0];
            e.ovf      = r54[64];
            exp54Q.push_back(e);
        end
        @(negedge clk);
        bus.r_enable = 1'b0;
    endtask

    task automatic drainRuns();
        int guard = 0;
        while ((exp64Q.size() != 0 || exp54Q.size() != 0 || bus.busy) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) reportTimeout("drain");
        @(negedge clk);
    endtask

    // Monitor for the 64-bit engine: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : mon64
        exp_t e;
        if (bus.w_enable) begin
            if (exp64Q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected w_enable64: got 1, wanted 0 at cycle %0d", cyc);
            end else begin
                e = exp64Q.pop_front();
                checkOutput("result64", bus.result, e.res);
                checkOutput("overflow64", 64'(bus.overflow), 64'(e.ovf));
                checkOutput("latency64", 64'(cyc - e.startCyc), 64'(e.lat));
                checkOutput("busy on done64", 64'(bus.busy), 64'd1);
            end
        end
    end

    // Monitor for the 54-bit engine.
    always @(negedge clk) begin : mon54
        exp_t e;
        if (bus54.w_enable) begin
            if (exp54Q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected w_enable54: got 1, wanted 0 at cycle %0d", cyc);
            end else begin
                e = exp54Q.pop_front();
                checkOutput("result54", 64'(bus54.result), e.res);
                checkOutput("overflow54", 64'(bus54.overflow), 64'(e.ovf));
                checkOutput("latency54", 64'(cyc - e.startCyc), 64'(e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int        sel;
        logic [63:0] seed;
        bus.r_enable            = 1'b0;
        bus.init_i              = '0;
        bus.n                   = '0;
        bus.init_acc            = '0;
        bus.mode                = '0;
        bus.controlArr          = 1'b0;
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrAddr_a    = '0;
        bus.controlArrWData_a   = '0;
        rst_n                   = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] long sum-of-squares run");
        for (int a = 0; a < DEPTH; a++)
            loadWord(a, (a < 1000) ? int'($urandom_range((1 << 26) - 1, 0)) : 0);
        for (int i = 0; i < 4; i++) checkReadback(int'($urandom_range(DEPTH - 1, 0)));
        applyStimulus(64'd0, 1000, 2'd0, 64'd0, 1'b1);
        drainRuns();

        $display("[TB] signed edge values in all modes");
        loadWord(100, -3);
        loadWord(101, 4);
        loadWord(102, -(1 << 26));
        loadWord(103, 5);
        checkReadback(102);
        applyStimulus(64'd100, 4, 2'd1, 64'd0, 1'b1);
        applyStimulus(64'd100, 4, 2'd2, 64'd0, 1'b1);
        applyStimulus(64'd100, 4, 2'd0, 64'd0, 1'b1);
        applyStimulus(64'd100, 4, 2'd3, 64'd0, 1'b1);
        drainRuns();

        $display("[TB] address wrap and empty run");
        loadWord(1022, 1);
        loadWord(1023, 2);
        loadWord(0, 3);
        loadWord(1, 4);
        applyStimulus(64'hDEAD_0000_0000_07FE, 4, 2'd0, 64'd0, 1'b1);
        applyStimulus(64'd5, 0, 2'd0, 64'd77, 1'b1);
        drainRuns();

        $display("[TB] start and host write ignored while busy");
        applyStimulus(64'd300, 10, 2'd0, 64'd0, 1'b1);
        repeat (2) @(negedge clk);
        bus.n        = 11'd3;
        bus.r_enable = 1'b1;
        @(negedge clk);
        bus.r_enable            = 1'b0;
        bus.controlArr          = 1'b1;
        bus.controlArrWEnable_a = 1'b1;
        bus.controlArrAddr_a    = 10'd305;
        bus.controlArrWData_a   = 27'h1234;
        @(negedge clk);
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArr          = 1'b0;
        drainRuns();
        applyStimulus(64'd300, 10, 2'd0, 64'd0, 1'b1);
        drainRuns();
        bus.controlArr = 1'b1;
        bus.n          = 11'd5;
        bus.r_enable   = 1'b1;
        @(negedge clk);
        bus.r_enable   = 1'b0;
        bus.controlArr = 1'b0;
        checkOutput("start ignored while host owns", 64'(bus.busy), 64'd0);

        $display("[TB] reset in the middle of a run");
        applyStimulus(64'd400, 100, 2'd1, 64'd9, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetState();
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(64'd400, 100, 2'd1, 64'd9, 1'b1);
        drainRuns();

        $display("[TB] accumulator overflow");
        for (int i = 0; i < 8; i++) loadWord(200 + i, -(1 << 26));
        applyStimulus(64'd200, 8, 2'd0, 64'd0, 1'b1);
        applyStimulus(64'd200, 8, 2'd1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
        applyStimulus(64'd200, 8, 2'd2, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
        drainRuns();

        $display("[TB] randomized back-to-back runs");
        for (int i = 0; i < 64; i++)
            loadWord(int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range((1 << 27) - 1, 0)) - (1 << 26));
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(2, 0));
            if (sel == 0)      seed = 64'd0;
            else if (sel == 1) seed = 64'($urandom);
            else               seed = {32'hFFFF_FFFF, $urandom};
            applyStimulus({$urandom, $urandom}, int'($urandom_range(40, 0)),
                          2'($urandom_range(3, 0)), seed, 1'b1);
        end
        drainRuns();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/norm_engine.md
# norm_engine

Parametrised successor of the single-mode norm² unit: an array-reduction engine with an internal single-port BRAM, host load/readback port, runtime-selectable reduction mode (L2², L1, L∞) and a runtime element count. The host fills the BRAM through the `controlArr*` port, pulses `r_enable` and receives `result` with a one-cycle `w_enable` pulse. It sits where the fixed-length norm² `main` sits and is driven by the same style of bench.

## Interface
- `DATA_W`, 27: signed element width.
- `ADDR_W`, 10: BRAM address width; depth = 2**ADDR_W.
- `ACC_W`, 64: accumulator/result width; must be ≥ 2*DATA_W.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `r_enable` in 1: start strobe, sampled in IDLE only.
- `init_i` in 64: start index; low ADDR_W bits used.
- `n` in ADDR_W+1: element count, 0..2**ADDR_W.
- `init_acc` in ACC_W: accumulator seed.
- `mode` in 2: 0 = Σx², 1 = Σ|x|, 2 = max|x|, 3 = reserved (treated as 0).
- `w_enable` out 1: one-cycle done pulse.
- `result` out ACC_W: final value; held until next start.
- `busy` out 1: high from start edge until the `w_enable` cycle inclusive.
- `overflow` out 1: sticky per run; see Configuration.
- `controlArr` in 1: host owns BRAM when high and engine IDLE.
- `controlArrWEnable_a` in 1; `controlArrAddr_a` in ADDR_W; `controlArrWData_a` in DATA_W signed; `controlArrRData_a` out DATA_W signed: host BRAM port, synchronous read, 1-cycle latency.

## Operation
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: `r_enable`=1 and `controlArr`=0 latch `init_i`, `n`, `mode`, `init_acc` into shadow registers; acc ← `init_acc`; go RUN (or DRAIN when `n`=0). `r_enable` with `controlArr`=1 is ignored.
- RUN: issue address (`init_i`+k) mod 2**ADDR_W for k = 0..n−1, one per cycle; go DRAIN after last issue. Wrap-around past top address is required, not an error.
- Pipeline: BRAM read (1) → op stage (1): |x| and x² registered → accumulate (1).
- |x| of −2^(DATA_W−1) = 2^(DATA_W−1) exactly (zero-extended, no sign flip). x² computed as unsigned 2*DATA_W product.
- Mode 2: acc ← max(acc, |x|), unsigned compare; `init_acc` participates.
- DRAIN: wait until pipeline empty; DONE: `result` ← acc, `w_enable`=1, then IDLE.
- `r_enable` during busy: ignored. Host port commands during busy: ignored, `controlArrRData_a` undefined.
- Reset mid-run: FSM → IDLE, run abandoned, no `w_enable`; BRAM contents retained.

## Timing
- Reset values: `w_enable`=0, `busy`=0, `overflow`=0, `result`=0, `controlArrRData_a`=0.
- Start edge E0 (r_enable sampled). `w_enable` high in the cycle after edge E0+n+3, i.e. latency n+4 cycles edge-to-pulse; n=0 gives latency 2 with `result`=`init_acc`.
- Throughput: one element per cycle; back-to-back runs: next `r_enable` accepted the cycle after `w_enable`.
- `result` and `overflow` update on the same edge that raises `w_enable`.

## Configuration
- `NORM_ENGINE_SAT_EN` defined: accumulation (modes 0/1) saturates at 2**ACC_W−1; `overflow` sets on first saturating add and holds until next start.
- Undefined: accumulation wraps modulo 2**ACC_W; `overflow` still sets on carry-out of the accumulator but `result` is the wrapped value.
- Mode 2 never overflows in either build.

## Test plan
- Load 1000 random values in [0, 2^26−1], `init_i`=0, `n`=1000, mode 0 → `result` = Σx² (64-bit golden), `w_enable` exactly 1004 cycles after start edge.
- Load [−3, 4, −2^26, 5], mode 1 and mode 2, `init_acc`=0 → 2^26+12 and 2^26 respectively; mode 0 → 2^52+50.
- `init_i`=1022, `n`=4, entries 1022,1023,0,1 = 1,2,3,4, mode 0 → 30 (wrap-around).
- `n`=0, `init_acc`=77 → `result`=77, latency 2; `r_enable` re-pulsed mid-run of n=10 → ignored, single `w_enable`.
- `rst_n` low at cycle 5 of a n=100 run → no `w_enable`, outputs reset; rerun with same data → correct result.
- `ACC_W`=54, all entries −2^26, n=8, mode 0: with SAT_EN → `result`=2^54−1, `overflow`=1; without → wrapped value 2^55 mod 2^54 = 0, `overflow`=1.
